// File: rtl/alu_pkg.sv
// Shared ALU lab definitions: FSM state encoding and default datapath width.
package alu_pkg;
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  localparam int ALU_WIDTH = 8;
endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = a - b - bi, bo = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock through a single
// full-subtractor cell with a registered borrow.
module serial_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             a_msb, b_msb;
  logic             cell_d, cell_bo;
  logic             last_bit;
  logic [WIDTH-1:0] res_next;

  full_subtractor u_cell (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .bi (br),
    .d  (cell_d),
    .bo (cell_bo)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign res_next = {cell_d, res_sr[WIDTH-1:1]};
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= bin;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          br     <= cell_bo;
          cnt    <= cnt + 1'b1;
          // Publish on the edge that retires the last bit so the outputs
          // are already valid while done is high.
          if (last_bit) begin
            state <= DONE;
            diff  <= res_next;
            bout  <= cell_bo;
            ovf   <= (a_msb != b_msb) && (cell_d != a_msb);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor with a queue-based result scoreboard.
module tb_serial_subtractor;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         bin = 1'b0;
  logic         busy, done, bout, ovf;
  logic [W-1:0] diff;

  exp_t exp_q[$];
  int   ncmp = 0;
  int   nerr = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] full;
    exp_t e;
    full   = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
    e.diff = full[W-1:0];
    e.bout = full[W];
    e.ovf  = (x[W-1] != y[W-1]) && (full[W-1] != x[W-1]);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a request, push its expectation, return #1 after the accepting edge.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                          input bit expect_result);
    start = 1'b1; a = x; b = y; bin = c;
    if (expect_result) exp_q.push_back(model(x, y, c));
    step();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
  endtask

  // Poll for done with a bound, then check latency and pop/compare.
  task automatic expect_done(input string tag, input int lat);
    int   cyc = 0;
    int   busy_cnt = 0;
    exp_t e;
    while (!done && cyc < 4 * W) begin
      if (busy === 1'b1) busy_cnt++;
      step();
      cyc++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_latency"}, 32'(cyc), 32'(lat));
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(lat));
    chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_diff"}, 32'(diff), 32'(e.diff));
      chk({tag, "_bout"}, 32'(bout), 32'(e.bout));
      chk({tag, "_ovf"},  32'(ovf),  32'(e.ovf));
    end
  endtask

  initial begin
    #2;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_diff", 32'(diff), 32'd0);
    chk("reset_bout", 32'(bout), 32'd0);
    chk("reset_ovf",  32'(ovf),  32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Basic subtract, then one-cycle done pulse and held result
    start_op(8'h05, 8'h03, 1'b0, 1'b1);
    expect_done("basic", W);
    step();
    chk("basic_pulse_width", 32'(done), 32'd0);
    chk("basic_hold_diff", 32'(diff), 32'h02);

    start_op(8'h03, 8'h05, 1'b0, 1'b1);
    expect_done("underflow", W);
    step();

    start_op(8'h80, 8'h01, 1'b0, 1'b1);
    expect_done("sovf", W);
    step();

    start_op(8'h00, 8'h00, 1'b1, 1'b1);
    expect_done("borrow_in", W);
    step();

    // Start while busy is ignored
    start_op(8'h10, 8'h01, 1'b0, 1'b1);
    start = 1'b1; a = 8'hAA; b = 8'h00; bin = 1'b1;
    step(); step(); step();
    start = 1'b0;
    chk("busy_hold_diff", 32'(diff), 32'hFF);
    expect_done("start_busy", W - 3);

    // Back-to-back start in the DONE cycle
    start = 1'b1; a = 8'h20; b = 8'h20; bin = 1'b0;
    exp_q.push_back(model(8'h20, 8'h20, 1'b0));
    step();
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_hold_diff", 32'(diff), 32'h0F);
    expect_done("b2b", W);
    step();

    // Make outputs non-zero before the reset test
    start_op(8'h00, 8'h00, 1'b1, 1'b1);
    expect_done("pre_rst", W);
    step();

    // Reset during the 4th RUN cycle
    start_op(8'hFF, 8'h01, 1'b0, 1'b0);
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    chk("rst_ovf",  32'(ovf),  32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      step();
      chk("rst_no_done", 32'(done), 32'd0);
    end

    start_op(8'h09, 8'h04, 1'b0, 1'b1);
    expect_done("after_rst", W);
    step();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
